// File: rtl/sum_tx_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_tx_sequencer_pkg
// Purpose  : Shared definitions for the sum UART frame sequencer: FSM state
//            encoding, fixed ASCII characters of the frame, frame length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sum_tx_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [7:0] C_ASCII_PLUS = 8'h2B;
  localparam logic [7:0] C_ASCII_EQ   = 8'h3D;
  localparam logic [7:0] C_ASCII_CR   = 8'h0D;
  localparam logic [7:0] C_ASCII_LF   = 8'h0A;

  localparam int C_FRAME_LEN = 8;
  localparam int C_IDX_W     = $clog2(C_FRAME_LEN);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_FRAME_LEN - 1);

endpackage
`default_nettype wire

// File: rtl/sum_tx_sequencer_hex_to_ascii.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_ascii
// Purpose  : Converts one hex nibble to its uppercase ASCII character.
// Ports    : nibble [3:0] in  - value 0..F
//            ascii  [7:0] out - '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0x37 + 10 = 0x41 ('A'), so letters share the same adder form as digits
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      ascii = 8'h37 + {4'h0, nibble};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sum_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sum_tx_sequencer
// Purpose  : On each rising edge of uart_tx_en, sends the 8-byte ASCII frame
//            "A+B=SS\r\n" to a byte transmitter, one byte per busy handshake.
// Ports    : clk, reset_n        - clock, async active-low reset
//            uart_tx_en          - async request level (rising edge = frame)
//            a_val, b_val, sum_val - operands and sum, snapshotted per frame
//            uart_tx_busy        - transmitter busy handshake
//            tx_data, tx_start   - byte and load strobe to the transmitter
//            frame_busy, frame_done, tx_err - frame status
// Revision : 1.0 - initial release
// ============================================================================
module sum_tx_sequencer
  import sum_tx_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       uart_tx_en,
  input  logic [3:0] a_val,
  input  logic [3:0] b_val,
  input  logic [4:0] sum_val,
  input  logic       uart_tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       frame_busy,
  output logic       frame_done,
  output logic       tx_err
);

  localparam int C_CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_sync1, r_sync2, r_hist;
  logic [1:0]           r_vld;
  logic                 r_armed;
  logic                 r_pending;
  logic [C_IDX_W-1:0]   r_idx;
  logic [C_CNT_W-1:0]   r_ack_cnt;
  logic [3:0]           r_a, r_b;
  logic [4:0]           r_sum;
  logic                 r_done, r_err;
  logic                 w_req, w_start_frame, w_abort, w_last_done, w_next_byte;
  logic [3:0]           w_nibble;
  logic [7:0]           w_hex;
  logic [7:0]           w_byte;

  // r_vld marks when r_sync2 carries a real post-reset sample. A request is
  // only armed once the pin has been seen low, so a level held high across
  // reset release never looks like a fresh rising edge.
  assign w_req = r_sync2 & ~r_hist & r_armed;

  always_comb begin
    w_state_nxt   = r_state;
    w_start_frame = 1'b0;
    w_abort       = 1'b0;
    w_last_done   = 1'b0;
    w_next_byte   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req || r_pending) begin
          w_state_nxt   = ST_SEND;
          w_start_frame = 1'b1;
        end
      end
      ST_SEND: w_state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (uart_tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_ack_cnt == C_CNT_W'(ACK_TIMEOUT - 1)) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (r_idx == C_LAST_IDX) begin
            w_state_nxt = ST_IDLE;
            w_last_done = 1'b1;
          end else begin
            w_state_nxt = ST_SEND;
            w_next_byte = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_hist    <= 1'b0;
      r_vld     <= 2'b00;
      r_armed   <= 1'b0;
      r_pending <= 1'b0;
      r_idx     <= '0;
      r_ack_cnt <= '0;
      r_a       <= 4'h0;
      r_b       <= 4'h0;
      r_sum     <= 5'h00;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= uart_tx_en;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end

      // Requests outside IDLE (including the last WAIT_DONE cycle) queue
      // one pending frame; extra ones are dropped.
      if (w_start_frame || w_abort) begin
        r_pending <= 1'b0;
      end else if (r_state != ST_IDLE && w_req) begin
        r_pending <= 1'b1;
      end

      if (w_start_frame) begin
        r_idx <= '0;
        r_a   <= a_val;
        r_b   <= b_val;
        r_sum <= sum_val;
      end else if (w_next_byte) begin
        r_idx <= r_idx + 1'b1;
      end

      if (r_state == ST_SEND) begin
        r_ack_cnt <= '0;
      end else if (r_state == ST_WAIT_ACK && !uart_tx_busy) begin
        r_ack_cnt <= r_ack_cnt + 1'b1;
      end

      r_done <= w_last_done;

      if (w_start_frame) begin
        r_err <= 1'b0;
      end else if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  // Nibble select feeds the single converter; byte select picks the frame
  // character. Kept as two blocks so the converter is not in a comb loop.
  always_comb begin
    case (r_idx)
      3'd0:    w_nibble = r_a;
      3'd2:    w_nibble = r_b;
      3'd4:    w_nibble = {3'b000, r_sum[4]};
      default: w_nibble = r_sum[3:0];
    endcase
  end

  hex_to_ascii u_hex_to_ascii (
    .nibble (w_nibble),
    .ascii  (w_hex)
  );

  always_comb begin
    case (r_idx)
      3'd1:    w_byte = C_ASCII_PLUS;
      3'd3:    w_byte = C_ASCII_EQ;
      3'd6:    w_byte = C_ASCII_CR;
      3'd7:    w_byte = C_ASCII_LF;
      default: w_byte = w_hex;
    endcase
  end

  assign tx_data    = (r_state == ST_IDLE) ? 8'h00 : w_byte;
  assign tx_start   = (r_state == ST_SEND);
  assign frame_busy = (r_state != ST_IDLE);
  assign frame_done = r_done;
  assign tx_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sum_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_tx_sequencer
// Purpose  : Self-checking bench for sum_tx_sequencer. Expected frame bytes
//            are queued when a request is made and compared on each tx_start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_tx_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_tx_en = 1'b0;
  logic       uart_tx_busy = 1'b0;
  logic [3:0] a_val = 4'h0;
  logic [3:0] b_val = 4'h0;
  logic [4:0] sum_val = 5'h00;
  logic [7:0] tx_data;
  logic       tx_start, frame_busy, frame_done, tx_err;

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_starts = 0;
  int   n_done = 0;
  bit   busy_model_en = 1'b1;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  sum_tx_sequencer #(.ACK_TIMEOUT(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .uart_tx_en   (uart_tx_en),
    .a_val        (a_val),
    .b_val        (b_val),
    .sum_val      (sum_val),
    .uart_tx_busy (uart_tx_busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .tx_err       (tx_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) hexc = 8'h30 + {4'h0, n};
    else           hexc = 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

  task automatic push_frame(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
    logic [3:0] hi;
    hi = {3'b000, s[4]};
    sb.push_back(hexc(a));
    sb.push_back(8'h2B);
    sb.push_back(hexc(b));
    sb.push_back(8'h3D);
    sb.push_back(hexc(hi));
    sb.push_back(hexc(s[3:0]));
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
  endtask

  task automatic wait_start(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (tx_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'h0, seen}, 32'h1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'h0, seen}, 32'h1);
  endtask

  task automatic pulse_en();
    uart_tx_en = 1'b1;
    repeat (3) @(negedge clk);
    uart_tx_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor: every tx_start pops one expected byte.
  initial forever begin
    @(negedge clk);
    if (reset_n && tx_start) begin
      n_starts++;
      if (sb.size() == 0) begin
        n_checks++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_tx_start: observed tx_data 0x%0h expected no tx_start", tx_data);
        end
      end else begin
        chk("tx_data", {24'h0, tx_data}, {24'h0, sb.pop_front()});
      end
    end
    if (frame_done) n_done++;
  end

  // Transmitter model: busy rises 2 cycles after the strobe, lasts 10 cycles.
  initial forever begin
    @(negedge clk);
    if (tx_start && busy_model_en) begin
      repeat (2) @(negedge clk);
      uart_tx_busy = 1'b1;
      repeat (10) @(negedge clk);
      uart_tx_busy = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0;

    // ---- reset state
    #1;
    chk("rst tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst frame_busy", {31'h0, frame_busy}, 32'h0);
    chk("rst frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst tx_err", {31'h0, tx_err}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // ---- 7+9=16, start latency of 3 edges from idle
    #2 d0 = n_done;
    @(negedge clk);
    a_val = 4'h7; b_val = 4'h9; sum_val = 5'h10;
    push_frame(4'h7, 4'h9, 5'h10);
    uart_tx_en = 1'b1;
    @(posedge clk); #1;
    chk("lat edge1 tx_start", {31'h0, tx_start}, 32'h0);
    chk("idle tx_data", {24'h0, tx_data}, 32'h0);
    @(posedge clk); #1;
    chk("lat edge2 tx_start", {31'h0, tx_start}, 32'h0);
    @(posedge clk); #1;
    chk("lat edge3 tx_start", {31'h0, tx_start}, 32'h1);
    chk("lat edge3 frame_busy", {31'h0, frame_busy}, 32'h1);
    repeat (3) @(negedge clk);
    uart_tx_en = 1'b0;
    wait_done("f79 done");
    chk("f79 busy after done", {31'h0, frame_busy}, 32'h0);
    repeat (3) @(negedge clk);
    #2;
    chk("f79 done count", n_done - d0, 32'd1);
    chk("f79 sb empty", sb.size(), 32'd0);

    // ---- F+F=1E, inputs change mid-frame
    @(negedge clk);
    a_val = 4'hF; b_val = 4'hF; sum_val = 5'h1E;
    push_frame(4'hF, 4'hF, 5'h1E);
    uart_tx_en = 1'b1;
    wait_start("fFF b0");
    uart_tx_en = 1'b0;
    wait_start("fFF b1");
    wait_start("fFF b2");
    a_val = 4'h0; b_val = 4'h0; sum_val = 5'h00;
    wait_done("fFF done");
    repeat (3) @(negedge clk);
    #2;
    chk("fFF sb empty", sb.size(), 32'd0);

    // ---- ack timeout
    @(negedge clk);
    busy_model_en = 1'b0;
    a_val = 4'h3; b_val = 4'h4; sum_val = 5'h07;
    sb.push_back(hexc(4'h3));
    #2 d0 = n_done;
    @(negedge clk);
    uart_tx_en = 1'b1;
    wait_start("to b0");
    uart_tx_en = 1'b0;
    repeat (16) @(negedge clk);
    chk("to before tx_err", {31'h0, tx_err}, 32'h0);
    chk("to before frame_busy", {31'h0, frame_busy}, 32'h1);
    @(negedge clk);
    chk("to tx_err", {31'h0, tx_err}, 32'h1);
    chk("to frame_busy", {31'h0, frame_busy}, 32'h0);
    repeat (20) @(negedge clk);
    chk("to tx_err sticky", {31'h0, tx_err}, 32'h1);
    #2;
    chk("to no frame_done", n_done - d0, 32'd0);
    busy_model_en = 1'b1;
    push_frame(4'h3, 4'h4, 5'h07);
    @(negedge clk);
    uart_tx_en = 1'b1;
    wait_start("to retry b0");
    chk("to err cleared", {31'h0, tx_err}, 32'h0);
    uart_tx_en = 1'b0;
    wait_done("to retry done");

    // ---- three requests during a frame -> two frames
    repeat (5) @(negedge clk);
    #2 d0 = n_done;
    @(negedge clk);
    a_val = 4'h1; b_val = 4'h2; sum_val = 5'h03;
    push_frame(4'h1, 4'h2, 5'h03);
    uart_tx_en = 1'b1;
    wait_start("pend f1 b0");
    uart_tx_en = 1'b0;
    a_val = 4'h5; b_val = 4'h6; sum_val = 5'h0B;
    push_frame(4'h5, 4'h6, 5'h0B);
    repeat (3) @(negedge clk);
    pulse_en();
    pulse_en();
    pulse_en();
    wait_done("pend f1 done");
    wait_done("pend f2 done");
    repeat (60) @(negedge clk);
    #2;
    chk("pend done count", n_done - d0, 32'd2);
    chk("pend sb empty", sb.size(), 32'd0);
    chk("pend idle", {31'h0, frame_busy}, 32'h0);

    // ---- request coincident with frame_done
    @(negedge clk);
    #2 d0 = n_done;
    a_val = 4'h2; b_val = 4'h2; sum_val = 5'h04;
    push_frame(4'h2, 4'h2, 5'h04);
    uart_tx_en = 1'b1;
    wait_start("coin b0");
    uart_tx_en = 1'b0;
    for (int i = 1; i < 8; i++) wait_start("coin bN");
    repeat (11) @(negedge clk);
    a_val = 4'h9; b_val = 4'h0; sum_val = 5'h09;
    push_frame(4'h9, 4'h0, 5'h09);
    uart_tx_en = 1'b1;
    @(negedge clk);
    chk("coin pre done", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    chk("coin frame_done", {31'h0, frame_done}, 32'h1);
    @(negedge clk);
    chk("coin f2 tx_start", {31'h0, tx_start}, 32'h1);
    chk("coin f2 tx_data", {24'h0, tx_data}, 32'h39);
    repeat (3) @(negedge clk);
    uart_tx_en = 1'b0;
    wait_done("coin f2 done");
    repeat (3) @(negedge clk);
    #2;
    chk("coin done count", n_done - d0, 32'd2);

    // ---- reset during byte 4, en held high through release
    @(negedge clk);
    a_val = 4'h4; b_val = 4'h5; sum_val = 5'h09;
    push_frame(4'h4, 4'h5, 5'h09);
    uart_tx_en = 1'b1;
    wait_start("rst b0");
    for (int i = 1; i < 5; i++) wait_start("rst bN");
    repeat (4) @(negedge clk);
    #2 d0 = n_done;
    reset_n = 1'b0;
    #1;
    chk("mid rst tx_data", {24'h0, tx_data}, 32'h0);
    chk("mid rst tx_start", {31'h0, tx_start}, 32'h0);
    chk("mid rst frame_busy", {31'h0, frame_busy}, 32'h0);
    chk("mid rst frame_done", {31'h0, frame_done}, 32'h0);
    chk("mid rst tx_err", {31'h0, tx_err}, 32'h0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #2 s0 = n_starts;
    repeat (30) @(negedge clk);
    #2;
    chk("held en no start", n_starts - s0, 32'd0);
    chk("held en idle", {31'h0, frame_busy}, 32'h0);
    chk("rst no frame_done", n_done - d0, 32'd0);
    @(negedge clk);
    uart_tx_en = 1'b0;
    repeat (4) @(negedge clk);
    push_frame(4'h4, 4'h5, 5'h09);
    uart_tx_en = 1'b1;
    wait_start("post rst b0");
    uart_tx_en = 1'b0;
    wait_done("post rst done");
    repeat (3) @(negedge clk);
    #2;
    chk("post rst sb empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_tx_sequencer.md
SUM_TX_SEQUENCER -- requirements
Module: sum_tx_sequencer

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16: max clk cycles waited for uart_tx_busy to rise after tx_start.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 uart_tx_en  input  1  asynchronous request level from pin; rising edge requests one frame.
REQ-005 a_val  input  4  latched operand A.
REQ-006 b_val  input  4  latched operand B.
REQ-007 sum_val  input  5  A+B from adder datapath.
REQ-008 uart_tx_busy  input  1  byte transmitter busy, high while shifting a byte.
REQ-009 tx_data  output  8  ASCII byte presented to transmitter.
REQ-010 tx_start  output  1  one-cycle strobe; transmitter loads tx_data.
REQ-011 frame_busy  output  1  high from frame start until last byte completes.
REQ-012 frame_done  output  1  one-cycle pulse after last byte completes.
REQ-013 tx_err  output  1  sticky ack-timeout flag.

Function
REQ-014 uart_tx_en SHALL pass a 2-flop synchronizer plus a history flop; request = sync & ~history.
REQ-015 Frame SHALL be 8 bytes in order: hex(A), 0x2B '+', hex(B), 0x3D '=', hex(sum[4]), hex(sum[3:0]), 0x0D, 0x0A.
REQ-016 Hex digits SHALL be uppercase ASCII: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-017 a_val, b_val, sum_val SHALL be snapshotted when the frame starts; input changes mid-frame do not affect the frame.
REQ-018 States: IDLE, SEND, WAIT_ACK, WAIT_DONE.
REQ-019 IDLE: on request (or pending flag) -> SEND, snapshot, byte index = 0, frame_busy = 1.
REQ-020 SEND: tx_start = 1 for exactly one cycle with tx_data = byte[index] -> WAIT_ACK, ack counter cleared.
REQ-021 WAIT_ACK: uart_tx_busy = 1 -> WAIT_DONE; counter reaching ACK_TIMEOUT -> tx_err = 1, frame aborted, IDLE, no frame_done.
REQ-022 WAIT_DONE: uart_tx_busy = 0 -> if index = 7: IDLE, frame_done pulse, frame_busy = 0; else index + 1, SEND.
REQ-023 Byte index SHALL be 3 bits; never wraps mid-frame.
REQ-024 tx_data SHALL hold the current byte from SEND through WAIT_DONE; 0x00 in IDLE.
REQ-025 tx_start rises on the 3rd rising clk edge, counting the first edge sampling uart_tx_en = 1, when in IDLE.
REQ-026 Request during active frame SHALL set a one-deep pending flag; further requests while pending is set are dropped.
REQ-027 Pending frame SHALL start the cycle after frame_done, with a fresh snapshot.
REQ-028 Request in the same cycle as frame_done SHALL be treated as pending (not lost).
REQ-029 tx_err SHALL clear only at the start of the next frame or reset.
REQ-030 Pending flag SHALL clear on abort via timeout.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, index 0, pending 0, sync/history flops 0, tx_data 0x00, tx_start 0, frame_busy 0, frame_done 0, tx_err 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no frame_done; uart_tx_en held high through reset release SHALL NOT start a frame.

Structure
REQ-033 Shared package SHALL hold the state encoding, ASCII constants (0x2B, 0x3D, 0x0D, 0x0A), and frame length 8.
REQ-034 One sub-module hex_to_ascii (4-bit in, 8-bit out, combinational), instantiated once on the byte-select path.

Verification
REQ-035 A=7, B=9, sum=16, one uart_tx_en pulse; model busy 10 cycles per byte -> bytes 0x37, 0x2B, 0x39, 0x3D, 0x31, 0x30, 0x0D, 0x0A; one frame_done.
REQ-036 A=F, B=F, sum=1E -> 0x46, 0x2B, 0x46, 0x3D, 0x31, 0x45, 0x0D, 0x0A; A changed to 0 at byte 2 does not alter the frame.
REQ-037 Busy never rises -> tx_err = 1 after ACK_TIMEOUT cycles of WAIT_ACK; no frame_done; next request clears tx_err and sends the full frame.
REQ-038 Three requests during a frame -> exactly two frames total; second frame uses values present at its start.
REQ-039 reset_n pulsed low during byte 4 -> all outputs reset immediately; no further tx_start until a new rising edge of uart_tx_en.
REQ-040 Request coincident with frame_done -> second frame's tx_start occurs; timing per REQ-025 checked from idle.
